audio_codec_if: RTL and testbench

- Serial front end for the I2S audio codec (WM8731-style, codec in slave mode).
- Generates the bit clock and LR clocks, and deserializes ADC data into parallel left/right samples.
- Serializes parallel DAC samples back to the codec.
- Produces the sample_end/sample_req strobes that drive the effects stage, which sits directly downstream for capture and upstream for playback.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_bclk_gen.sv | 61 ++++++
 rtl/audio_codec_if.sv | 122 ++++++++++++
 tb/tb_audio_codec_if.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S codec front end.
package audio_pkg;

  localparam int DEF_SAMPLE_BITS = 16;

  // Strobe bit positions in sample_end / sample_req.
  localparam int CH_L = 1;
  localparam int CH_R = 0;

  typedef logic signed [DEF_SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider, frame bit index and LR clock generation.
module audio_bclk_gen #(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8,
  localparam int BW = $clog2(2 * SLOT_BITS),
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          bclk,
  output logic          lrclk,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic [BW-1:0] bit_idx,
  output logic [BW-1:0] bit_idx_nxt
);

  localparam logic [DW-1:0] D_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_BITS);

  logic [DW-1:0] d_q, d_d;
  logic [BW-1:0] b_q, b_d;
  logic          bclk_q, bclk_d;
  logic          lr_q, lr_d;
  logic          tick;

  always_comb begin
    tick      = (d_q == D_LAST);
    d_d       = tick ? '0 : d_q + 1'b1;
    bclk_d    = bclk_q ^ tick;
    rise_tick = tick & ~bclk_q;
    fall_tick = tick & bclk_q;
    b_d       = b_q;
    if (fall_tick) begin
      b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    end
    // LR follows the index that takes effect on this fall tick.
    lr_d = fall_tick ? (b_d >= B_RIGHT) : lr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= '0;
      b_q    <= B_LAST;
      bclk_q <= 1'b0;
      lr_q   <= 1'b0;
    end else begin
      d_q    <= d_d;
      b_q    <= b_d;
      bclk_q <= bclk_d;
      lr_q   <= lr_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lr_q;
  assign bit_idx     = b_q;
  assign bit_idx_nxt = b_d;

endmodule

// File: rtl/audio_codec_if.sv
// I2S front end for a slave-mode codec: ADC capture, DAC playback and the
// per-channel strobes that pace the effects stage.
module audio_codec_if #(
  parameter int SAMPLE_BITS = audio_pkg::DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_DIV    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   aud_bclk,
  output logic                   aud_adclrck,
  output logic                   aud_daclrck,
  input  logic                   aud_adcdat,
  output logic                   aud_dacdat,
  output logic [1:0]             sample_end,
  output logic [1:0]             sample_req,
  output logic [SAMPLE_BITS-1:0] audio_input_l,
  output logic [SAMPLE_BITS-1:0] audio_input_r,
  input  logic [SAMPLE_BITS-1:0] audio_output_l,
  input  logic [SAMPLE_BITS-1:0] audio_output_r
);
  import audio_pkg::*;

  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] B_L_REQ  = '0;
  localparam logic [BW-1:0] B_R_REQ  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] B_L_LOAD = BW'(1);
  localparam logic [BW-1:0] B_R_LOAD = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0] B_L_DONE = BW'(SAMPLE_BITS);
  localparam logic [BW-1:0] B_R_DONE = BW'(SLOT_BITS + SAMPLE_BITS);

  logic          bclk, lrclk, rise_tick, fall_tick;
  logic [BW-1:0] bit_idx, bit_idx_nxt;

  audio_bclk_gen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (clk),
    .reset       (reset),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .bit_idx     (bit_idx),
    .bit_idx_nxt (bit_idx_nxt)
  );

  logic [SAMPLE_BITS-1:0] dac_sr_q, dac_sr_d;
  logic [SAMPLE_BITS-1:0] cap_q, cap_d;
  logic [SAMPLE_BITS-1:0] in_l_q, in_l_d;
  logic [SAMPLE_BITS-1:0] in_r_q, in_r_d;
  logic [1:0]             end_q, end_d;
  logic [1:0]             req_q, req_d;
  logic                   started_q, started_d;

  always_comb begin
    dac_sr_d  = dac_sr_q;
    cap_d     = cap_q;
    in_l_d    = in_l_q;
    in_r_d    = in_r_q;
    end_d     = 2'b00;
    req_d     = 2'b00;
    started_d = started_q | fall_tick;

    if (fall_tick) begin
      if (bit_idx_nxt == B_L_REQ) req_d[CH_L] = 1'b1;
      if (bit_idx_nxt == B_R_REQ) req_d[CH_R] = 1'b1;
      // Loads land one bit after the LR edge to honour the I2S delay.
      if (bit_idx_nxt == B_L_LOAD) begin
        dac_sr_d = audio_output_l;
      end else if (bit_idx_nxt == B_R_LOAD) begin
        dac_sr_d = audio_output_r;
      end else begin
        dac_sr_d = {dac_sr_q[SAMPLE_BITS-2:0], 1'b0};
      end
    end

    if (rise_tick) begin
      cap_d = {cap_q[SAMPLE_BITS-2:0], aud_adcdat};
      // The pre-frame rise tick must not complete a capture.
      if (started_q && bit_idx == B_L_DONE) begin
        in_l_d      = cap_d;
        end_d[CH_L] = 1'b1;
      end
      if (started_q && bit_idx == B_R_DONE) begin
        in_r_d      = cap_d;
        end_d[CH_R] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_sr_q  <= '0;
      cap_q     <= '0;
      in_l_q    <= '0;
      in_r_q    <= '0;
      end_q     <= '0;
      req_q     <= '0;
      started_q <= 1'b0;
    end else begin
      dac_sr_q  <= dac_sr_d;
      cap_q     <= cap_d;
      in_l_q    <= in_l_d;
      in_r_q    <= in_r_d;
      end_q     <= end_d;
      req_q     <= req_d;
      started_q <= started_d;
    end
  end

  assign aud_bclk      = bclk;
  assign aud_adclrck   = lrclk;
  assign aud_daclrck   = lrclk;
  assign aud_dacdat    = dac_sr_q[SAMPLE_BITS-1];
  assign sample_end    = end_q;
  assign sample_req    = req_q;
  assign audio_input_l = in_l_q;
  assign audio_input_r = in_r_q;

endmodule

// File: tb/tb_audio_codec_if.sv
// Cycle-level check of audio_codec_if against a timing model derived from
// the cycle count since reset release.
module tb_audio_codec_if;

  localparam int SB    = 16;
  localparam int S     = 20;
  localparam int DIV   = 2;
  localparam int FRAME = 4 * S * DIV;

  localparam int MODE_RAND = 0;
  localparam int MODE_LOOP = 1;
  localparam int MODE_ZERO = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, aud_dacdat;
  logic [1:0]    sample_end, sample_req;
  logic [SB-1:0] audio_input_l, audio_input_r, audio_output_l, audio_output_r;

  always #5 clk = ~clk;

  audio_codec_if #(
    .SAMPLE_BITS (SB),
    .SLOT_BITS   (S),
    .BCLK_DIV    (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .aud_bclk       (aud_bclk),
    .aud_adclrck    (aud_adclrck),
    .aud_daclrck    (aud_daclrck),
    .aud_adcdat     (aud_adcdat),
    .aud_dacdat     (aud_dacdat),
    .sample_end     (sample_end),
    .sample_req     (sample_req),
    .audio_input_l  (audio_input_l),
    .audio_input_r  (audio_input_r),
    .audio_output_l (audio_output_l),
    .audio_output_r (audio_output_r)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model state: everything follows from n, the number of clk edges since
  // reset release.
  int            n, falls_m, b_m, frames, mode;
  logic [SB-1:0] adc_l, adc_r, word_l, word_r, exp_in_l, exp_in_r, drive_l, drive_r;
  int            cnt_req_l, cnt_req_r, cnt_end_l, cnt_end_r;

  task automatic model_reset();
    n        = 0;
    falls_m  = 0;
    b_m      = 2 * S - 1;
    frames   = 0;
    mode     = MODE_RAND;
    exp_in_l = '0;
    exp_in_r = '0;
    word_l   = '0;
    word_r   = '0;
  endtask

  function automatic logic [SB-1:0] dac_word(input logic [SB-1:0] drv, input logic [SB-1:0] captured);
    if (mode == MODE_LOOP) return captured;
    if (mode == MODE_ZERO) return '0;
    return drv;
  endfunction

  task automatic new_frame();
    if (frames == 1) begin
      adc_l   = 16'h8001;
      adc_r   = 16'h7FFE;
      drive_l = 16'hA5C3;
      drive_r = 16'h0001;
    end else begin
      adc_l = SB'($urandom);
      adc_r = SB'($urandom);
    end
    if (frames <= 40)      mode = MODE_RAND;
    else if (frames <= 70) mode = MODE_LOOP;
    else                   mode = MODE_ZERO;
  endtask

  // Called at the negedge after each clk edge: advance model, compare, drive.
  task automatic step_check();
    int            toggles, p;
    bit            rise, fall;
    logic [1:0]    e_req, e_end;
    logic          e_dac, e_lr, e_bclk;
    logic [SB-1:0] w;
    n++;
    toggles = n / DIV;
    rise    = (n % DIV == 0) && (toggles % 2 == 1);
    fall    = (n % DIV == 0) && (toggles % 2 == 0);
    falls_m = toggles / 2;
    b_m     = (falls_m == 0) ? 2 * S - 1 : (falls_m - 1) % (2 * S);
    e_req   = 2'b00;
    e_end   = 2'b00;
    if (fall) begin
      if (b_m == 0) begin
        e_req = 2'b10;
        frames++;
        new_frame();
      end
      if (b_m == S)     e_req  = 2'b01;
      if (b_m == 1)     word_l = dac_word(drive_l, exp_in_l);
      if (b_m == S + 1) word_r = dac_word(drive_r, exp_in_r);
    end
    if (rise && falls_m > 0) begin
      if (b_m == SB)     begin exp_in_l = adc_l; e_end = 2'b10; end
      if (b_m == S + SB) begin exp_in_r = adc_r; e_end = 2'b01; end
    end
    p     = b_m % S;
    e_dac = 1'b0;
    if (falls_m > 0 && p >= 1 && p <= SB) begin
      w     = (b_m < S) ? word_l : word_r;
      e_dac = w[SB-p];
    end
    e_bclk = 1'(toggles % 2);
    e_lr   = (falls_m > 0) && (b_m >= S);

    chk("bclk", aud_bclk, e_bclk);
    chk("adclrck", aud_adclrck, e_lr);
    chk("daclrck", aud_daclrck, e_lr);
    chk("dacdat", aud_dacdat, e_dac);
    chk("sample_req", sample_req, e_req);
    chk("sample_end", sample_end, e_end);
    chk("audio_input_l", audio_input_l, exp_in_l);
    chk("audio_input_r", audio_input_r, exp_in_r);
    chk("strobe_excl", (sample_req != 0) && (sample_end != 0), 0);

    cnt_req_l += sample_req[1];
    cnt_req_r += sample_req[0];
    cnt_end_l += sample_end[1];
    cnt_end_r += sample_end[0];

    // Next-edge stimulus: codec bits for the upcoming rise, playback words.
    if (mode == MODE_RAND && frames != 1) begin
      drive_l = SB'($urandom);
      drive_r = SB'($urandom);
    end
    if (falls_m > 0 && p >= 1 && p <= SB) begin
      w          = (b_m < S) ? adc_l : adc_r;
      aud_adcdat = w[SB-p];
    end else begin
      aud_adcdat = 1'($urandom);
    end
    audio_output_l = (mode == MODE_LOOP) ? audio_input_l : (mode == MODE_ZERO) ? '0 : drive_l;
    audio_output_r = (mode == MODE_LOOP) ? audio_input_r : (mode == MODE_ZERO) ? '0 : drive_r;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bclk"}, aud_bclk, 0);
    chk({tag, "_lrck"}, {aud_adclrck, aud_daclrck}, 0);
    chk({tag, "_dacdat"}, aud_dacdat, 0);
    chk({tag, "_strobes"}, {sample_req, sample_end}, 0);
    chk({tag, "_in_l"}, audio_input_l, 0);
    chk({tag, "_in_r"}, audio_input_r, 0);
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    aud_adcdat     = 1'b0;
    audio_output_l = '0;
    audio_output_r = '0;
    drive_l        = '0;
    drive_r        = '0;
    adc_l          = '0;
    adc_r          = '0;
    cnt_req_l = 0; cnt_req_r = 0; cnt_end_l = 0; cnt_end_r = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // 100 frames: random playback, then loopback, then silence.
    reset = 1'b0;
    for (int i = 0; i < 2 * DIV + 100 * FRAME - 1; i++) begin
      @(negedge clk);
      step_check();
    end
    chk("cnt_req_l", cnt_req_l, 100);
    chk("cnt_req_r", cnt_req_r, 100);
    chk("cnt_end_l", cnt_end_l, 100);
    chk("cnt_end_r", cnt_end_r, 100);

    // Abort in the middle of a right slot.
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      @(negedge clk);
      step_check();
      if (b_m == S + 5) found = 1'b1;
    end
    chk("find_right_slot", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME + 2 * DIV; i++) begin
      @(negedge clk);
      step_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
